// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem address/data, execute redirect and the decode valid/ready handshake.
// master = fetch_unit side, slave = the imem/execute/decode side.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_addr,
        input  imem_rd,
        input  branch_valid,
        input  branch_target,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rd,
        output branch_valid,
        output branch_target,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus prefetch FIFO feeding decode over valid/ready; redirects flush the FIFO.
// Optional macro FETCH_HALT_EN: stop fetching after the branch-to-self end-of-program word.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
`ifdef FETCH_HALT_EN
    output logic         halted,
`endif
    fetch_unit_if.master bus
);
    localparam int            PW        = $clog2(FIFO_DEPTH);
    localparam int            CW        = PW + 1;
    localparam logic [31:0]   PC_RST    = {RESET_PC[31:2], 2'b00};
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
    localparam logic [31:0]   HALT_WORD = 32'hEAFF_FFFE;

    logic [31:0]   pc_q;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          valid;
    logic          pop;
    logic          push;

    assign valid = (count != '0);
    assign pop   = valid & bus.instr_ready;

`ifdef FETCH_HALT_EN
    logic halt_q;

    assign push   = ~bus.branch_valid & ((count < DEPTH) | pop) & ~halt_q;
    assign halted = halt_q;

    // The halt word itself is still pushed; only later pushes are blocked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            halt_q <= 1'b0;
        else if (bus.branch_valid)
            halt_q <= 1'b0;
        else if (push && (bus.imem_rd == HALT_WORD))
            halt_q <= 1'b1;
    end
`else
    assign push = ~bus.branch_valid & ((count < DEPTH) | pop);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= PC_RST;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (bus.branch_valid) begin
            // A same-cycle pop has already been taken by decode; everything else is dropped.
            pc_q   <= {bus.branch_target[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= bus.imem_rd;
                fifo_pc[wr_ptr]    <= pc_q;
                wr_ptr             <= wr_ptr + PW'(1);
                pc_q               <= pc_q + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? fifo_instr[rd_ptr] : '0;
    assign bus.instr_pc    = valid ? fifo_pc[rd_ptr]    : '0;
endmodule
